// File: rtl/i2c_slave_byte_ctrl_pkg.sv
// Shared definitions for the I2C byte-level target: FSM state encodings,
// R/W bit position and the address-match helper.
package i2c_slave_byte_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_IGNORE    = 3'd7
    } state_t;

    localparam int         RW_BIT   = 0;
    localparam logic [3:0] LAST_BIT = 4'd7;
    localparam logic [3:0] BYTE_LEN = 4'd8;

    // General call (0x00) never matches, even if the own address were zero.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (addr_byte[7:1] != 7'h00);
    endfunction

endpackage

// File: rtl/i2c_slave_byte_ctrl_if.sv
// Pad-side I2C lines plus the local byte handshake of the I2C target.
interface i2c_slave_byte_ctrl_if;

    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic       sda_oen;
    logic       rx_nack;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_req;
    logic       addr_hit;
    logic       addr_rw;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    modport slave (
        input  scl_i, sda_i, rx_nack, tx_data,
        output sda_o, sda_oen, rx_valid, rx_data, tx_req,
               addr_hit, addr_rw, busy, start_det, stop_det
    );

    modport master (
        output scl_i, sda_i, rx_nack, tx_data,
        input  sda_o, sda_oen, rx_valid, rx_data, tx_req,
               addr_hit, addr_rw, busy, start_det, stop_det
    );

endinterface

// File: rtl/i2c_slave_filter.sv
// Pad conditioner: 2-FF synchronizer, stability counter and registered
// edge pulses that coincide with the filtered level change.
module i2c_slave_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       level_reg;
    logic       rise_reg;
    logic       fall_reg;
    logic [3:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            cnt_reg   <= 4'd0;
        end else begin
            sync1_reg <= pad;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            // Any sample equal to the current level restarts the stability count.
            if (sync2_reg == level_reg) begin
                cnt_reg <= 4'd0;
            end else if (cnt_reg == LAST) begin
                level_reg <= sync2_reg;
                rise_reg  <= sync2_reg;
                fall_reg  <= ~sync2_reg;
                cnt_reg   <= 4'd0;
            end else begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C target: START/STOP detection, 7-bit address match, ACK
// generation and byte transfer to/from a local handshake. SDA is open-drain.
module i2c_slave_byte_ctrl
    import i2c_slave_byte_ctrl_pkg::*;
#(
    parameter logic [6:0] ADDR       = 7'h1A,
    parameter int         FILTER_LEN = 3
) (
    input logic                  clk,
    input logic                  rst,
    i2c_slave_byte_ctrl_if.slave bus
);

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0] pad;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] fall;

    assign pad = {bus.sda_i, bus.scl_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
                .clk   (clk),
                .rst   (rst),
                .pad   (pad[gi]),
                .level (level[gi]),
                .rise  (rise[gi]),
                .fall  (fall[gi])
            );
        end
    endgenerate

    logic scl_f, sda_f, scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_f      = level[0];
    assign sda_f      = level[1];
    assign scl_rise   = rise[0];
    assign scl_fall   = fall[0];
    assign start_cond = fall[1] & scl_f;
    assign stop_cond  = rise[1] & scl_f;

    state_t     state_reg;
    logic [3:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [7:0] tx_shift_reg;
    logic       ack_phase_reg;
    logic       nack_reg;
    logic       sda_oen_reg;
    logic [7:0] rx_data_reg;
    logic       addr_rw_reg;
    logic       busy_reg;
    logic       rx_valid_reg;
    logic       tx_req_reg;
    logic       addr_hit_reg;
    logic       start_det_reg;
    logic       stop_det_reg;

    logic [7:0] shift_next;
    assign shift_next = {shift_reg[6:0], sda_f};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= 8'h00;
            tx_shift_reg  <= 8'h00;
            ack_phase_reg <= 1'b0;
            nack_reg      <= 1'b0;
            sda_oen_reg   <= 1'b1;
            rx_data_reg   <= 8'h00;
            addr_rw_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            rx_valid_reg  <= 1'b0;
            tx_req_reg    <= 1'b0;
            addr_hit_reg  <= 1'b0;
            start_det_reg <= 1'b0;
            stop_det_reg  <= 1'b0;
        end else begin
            rx_valid_reg  <= 1'b0;
            tx_req_reg    <= 1'b0;
            addr_hit_reg  <= 1'b0;
            start_det_reg <= 1'b0;
            stop_det_reg  <= 1'b0;

            if (start_cond) begin
                state_reg     <= ST_ADDR;
                bit_cnt_reg   <= 4'd0;
                ack_phase_reg <= 1'b0;
                sda_oen_reg   <= 1'b1;
                busy_reg      <= 1'b0;
                start_det_reg <= 1'b1;
            end else if (stop_cond) begin
                state_reg    <= ST_IDLE;
                sda_oen_reg  <= 1'b1;
                busy_reg     <= 1'b0;
                stop_det_reg <= 1'b1;
            end else begin
                case (state_reg)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= shift_next;
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg <= 4'd0;
                                if (addr_match(shift_next, ADDR)) begin
                                    addr_hit_reg  <= 1'b1;
                                    addr_rw_reg   <= shift_next[RW_BIT];
                                    busy_reg      <= 1'b1;
                                    ack_phase_reg <= 1'b0;
                                    state_reg     <= ST_ADDR_ACK;
                                end else begin
                                    state_reg <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall && !ack_phase_reg) begin
                            sda_oen_reg   <= 1'b0;
                            ack_phase_reg <= 1'b1;
                        end else if (scl_fall) begin
                            ack_phase_reg <= 1'b0;
                            bit_cnt_reg   <= 4'd0;
                            if (addr_rw_reg) begin
                                // First data bit goes out on the same edge as tx_req.
                                tx_req_reg   <= 1'b1;
                                tx_shift_reg <= bus.tx_data;
                                sda_oen_reg  <= bus.tx_data[7];
                                state_reg    <= ST_READ;
                            end else begin
                                sda_oen_reg <= 1'b1;
                                state_reg   <= ST_WRITE;
                            end
                        end
                    end

                    ST_WRITE: begin
                        if (scl_rise) begin
                            shift_reg <= shift_next;
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg   <= 4'd0;
                                rx_data_reg   <= shift_next;
                                rx_valid_reg  <= 1'b1;
                                nack_reg      <= bus.rx_nack;
                                ack_phase_reg <= 1'b0;
                                state_reg     <= ST_WRITE_ACK;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end

                    ST_WRITE_ACK: begin
                        if (scl_fall && !ack_phase_reg) begin
                            sda_oen_reg   <= nack_reg;
                            ack_phase_reg <= 1'b1;
                        end else if (scl_fall) begin
                            sda_oen_reg   <= 1'b1;
                            ack_phase_reg <= 1'b0;
                            bit_cnt_reg   <= 4'd0;
                            if (nack_reg) begin
                                busy_reg  <= 1'b0;
                                state_reg <= ST_IGNORE;
                            end else begin
                                state_reg <= ST_WRITE;
                            end
                        end
                    end

                    ST_READ: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_reg == BYTE_LEN) begin
                                sda_oen_reg   <= 1'b1;
                                ack_phase_reg <= 1'b0;
                                state_reg     <= ST_READ_ACK;
                            end else begin
                                sda_oen_reg  <= tx_shift_reg[6];
                                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                            end
                        end
                    end

                    ST_READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                busy_reg  <= 1'b0;
                                state_reg <= ST_IGNORE;
                            end else begin
                                ack_phase_reg <= 1'b1;
                            end
                        end else if (scl_fall && ack_phase_reg) begin
                            ack_phase_reg <= 1'b0;
                            bit_cnt_reg   <= 4'd0;
                            tx_req_reg    <= 1'b1;
                            tx_shift_reg  <= bus.tx_data;
                            sda_oen_reg   <= bus.tx_data[7];
                            state_reg     <= ST_READ;
                        end
                    end

                    ST_IDLE, ST_IGNORE: begin
                        sda_oen_reg <= 1'b1;
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_o     = 1'b0;
    assign bus.sda_oen   = sda_oen_reg;
    assign bus.rx_valid  = rx_valid_reg;
    assign bus.rx_data   = rx_data_reg;
    assign bus.tx_req    = tx_req_reg;
    assign bus.addr_hit  = addr_hit_reg;
    assign bus.addr_rw   = addr_rw_reg;
    assign bus.busy      = busy_reg;
    assign bus.start_det = start_det_reg;
    assign bus.stop_det  = stop_det_reg;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench: a bit-banged I2C master on a wired-AND bus drives the target
// through write, read, no-match, NACK, repeated START, glitch and reset cases.
module tb_i2c_slave_byte_ctrl;
    import i2c_slave_byte_ctrl_pkg::*;

    localparam int QTR = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic scl_m      = 1'b1;
    logic sda_m      = 1'b1;
    logic scl_glitch = 1'b0;
    logic rx_nack    = 1'b0;

    logic [7:0] tx_tbl [0:3];
    int         tx_base = 0;
    logic [1:0] tx_idx;

    i2c_slave_byte_ctrl_if bus_if ();

    assign bus_if.scl_i   = scl_m | scl_glitch;
    assign bus_if.sda_i   = sda_m & (bus_if.sda_oen | bus_if.sda_o);
    assign bus_if.rx_nack = rx_nack;
    assign bus_if.tx_data = tx_tbl[tx_idx];

    i2c_slave_byte_ctrl #(.ADDR(7'h1A), .FILTER_LEN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Event monitor; counters are only ever written here.
    int         hit_cnt = 0, rx_cnt = 0, tx_req_cnt = 0, start_cnt = 0, stop_cnt = 0, oen_low_cnt = 0;
    logic [1:0] rw_hist = 2'b00;

    assign tx_idx = 2'(tx_req_cnt - tx_base);

    always @(negedge clk) begin
        if (bus_if.addr_hit === 1'b1) begin
            hit_cnt++;
            rw_hist = {rw_hist[0], bus_if.addr_rw};
        end
        if (bus_if.rx_valid  === 1'b1) rx_cnt++;
        if (bus_if.tx_req    === 1'b1) tx_req_cnt++;
        if (bus_if.start_det === 1'b1) start_cnt++;
        if (bus_if.stop_det  === 1'b1) stop_cnt++;
        if (bus_if.sda_oen   === 1'b0) oen_low_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        wait_q(); sda_m = 1'b1;
        wait_q(); scl_m = 1'b1;
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_m = 1'b1;
        wait_q(); sda_m = 1'b1;
        wait_q();
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        wait_q(); sda_m = b;
        wait_q(); scl_m = 1'b1;
        wait_q(); s = bus_if.sda_i;
        wait_q(); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            d = {d[6:0], s};
        end
        bit_xfer(mack, s);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic       ack0, ack1, ack2;
        logic [7:0] d0, d1;
        int         h0, r0, t0, s0, p0, o0;

        tx_tbl[0] = 8'h00; tx_tbl[1] = 8'h00; tx_tbl[2] = 8'h00; tx_tbl[3] = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_sda_oen", 32'(bus_if.sda_oen), 32'd1);
        check_val("rst_rx_data", 32'(bus_if.rx_data), 32'h00);
        check_val("rst_addr_rw", 32'(bus_if.addr_rw), 32'd0);
        check_val("rst_busy",    32'(bus_if.busy),    32'd0);
        check_val("rst_state",   32'(dut.state_reg),  32'(ST_IDLE));
        $display("txn reset: done");

        // Write 0xA5 to 0x1A
        h0 = hit_cnt; r0 = rx_cnt; s0 = start_cnt; p0 = stop_cnt;
        i2c_start();
        send_byte(8'h34, ack0);
        check_val("wr_busy_mid", 32'(bus_if.busy), 32'd1);
        send_byte(8'hA5, ack1);
        i2c_stop();
        repeat (10) @(negedge clk);
        $display("txn write: addr 0x34 data 0xA5 ack %0b/%0b", ack0, ack1);
        check_val("wr_addr_ack", 32'(ack0), 32'd0);
        check_val("wr_data_ack", 32'(ack1), 32'd0);
        check_val("wr_hit_cnt",  32'(hit_cnt - h0), 32'd1);
        check_val("wr_addr_rw",  32'(rw_hist[0]), 32'd0);
        check_val("wr_rx_cnt",   32'(rx_cnt - r0), 32'd1);
        check_val("wr_rx_data",  32'(bus_if.rx_data), 32'hA5);
        check_val("wr_start",    32'(start_cnt - s0), 32'd1);
        check_val("wr_stop",     32'(stop_cnt - p0), 32'd1);
        check_val("wr_busy_end", 32'(bus_if.busy), 32'd0);

        // Read two bytes from 0x1A
        tx_base = tx_req_cnt;
        tx_tbl[0] = 8'h5A; tx_tbl[1] = 8'hC3;
        t0 = tx_req_cnt;
        i2c_start();
        send_byte(8'h35, ack0);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        repeat (5) @(negedge clk);
        $display("txn read: addr 0x35 data 0x%02h 0x%02h ack %0b", d0, d1, ack0);
        check_val("rd_addr_ack", 32'(ack0), 32'd0);
        check_val("rd_addr_rw",  32'(bus_if.addr_rw), 32'd1);
        check_val("rd_byte0",    32'(d0), 32'h5A);
        check_val("rd_byte1",    32'(d1), 32'hC3);
        check_val("rd_tx_req",   32'(tx_req_cnt - t0), 32'd2);
        check_val("rd_ignore",   32'(dut.state_reg), 32'(ST_IGNORE));
        check_val("rd_busy",     32'(bus_if.busy), 32'd0);
        i2c_stop();
        repeat (10) @(negedge clk);
        check_val("rd_idle",     32'(dut.state_reg), 32'(ST_IDLE));

        // Non-matching address 0x1B
        h0 = hit_cnt; o0 = oen_low_cnt; r0 = rx_cnt;
        i2c_start();
        send_byte(8'h36, ack0);
        send_byte(8'h55, ack1);
        i2c_stop();
        repeat (10) @(negedge clk);
        $display("txn nomatch: addr 0x36 ack %0b/%0b", ack0, ack1);
        check_val("nm_addr_nack", 32'(ack0), 32'd1);
        check_val("nm_data_nack", 32'(ack1), 32'd1);
        check_val("nm_hit_cnt",   32'(hit_cnt - h0), 32'd0);
        check_val("nm_oen_low",   32'(oen_low_cnt - o0), 32'd0);
        check_val("nm_rx_cnt",    32'(rx_cnt - r0), 32'd0);

        // Local NACK on second data byte
        r0 = rx_cnt;
        i2c_start();
        send_byte(8'h34, ack0);
        send_byte(8'h11, ack1);
        rx_nack = 1'b1;
        send_byte(8'h22, ack2);
        rx_nack = 1'b0;
        send_byte(8'h33, ack0);
        i2c_stop();
        repeat (10) @(negedge clk);
        $display("txn rx_nack: data 0x11 0x22 0x33 ack %0b/%0b/%0b", ack1, ack2, ack0);
        check_val("nk_byte1_ack", 32'(ack1), 32'd0);
        check_val("nk_byte2_nack", 32'(ack2), 32'd1);
        check_val("nk_byte3_nack", 32'(ack0), 32'd1);
        check_val("nk_rx_cnt",    32'(rx_cnt - r0), 32'd2);
        check_val("nk_rx_data",   32'(bus_if.rx_data), 32'h22);

        // Write 0x10, repeated START, read
        tx_base = tx_req_cnt;
        tx_tbl[0] = 8'h96; tx_tbl[1] = 8'hFF;
        s0 = start_cnt;
        i2c_start();
        send_byte(8'h34, ack0);
        send_byte(8'h10, ack1);
        i2c_rstart();
        send_byte(8'h35, ack2);
        read_byte(1'b1, d0);
        i2c_stop();
        repeat (10) @(negedge clk);
        $display("txn rstart: wr 0x10, rd 0x%02h, rw hist %02b", d0, rw_hist);
        check_val("rs_start_cnt", 32'(start_cnt - s0), 32'd2);
        check_val("rs_rw_hist",   32'(rw_hist), 32'b01);
        check_val("rs_rx_data",   32'(bus_if.rx_data), 32'h10);
        check_val("rs_addr_ack",  32'(ack2), 32'd0);
        check_val("rs_rd_data",   32'(d0), 32'h96);

        // Two-cycle SCL glitch must not shift a bit
        h0 = hit_cnt;
        i2c_start();
        wait_q();
        scl_glitch = 1'b1;
        repeat (2) @(negedge clk);
        scl_glitch = 1'b0;
        wait_q();
        send_byte(8'h34, ack0);
        i2c_stop();
        repeat (10) @(negedge clk);
        $display("txn glitch: addr 0x34 after glitch ack %0b", ack0);
        check_val("gl_addr_ack", 32'(ack0), 32'd0);
        check_val("gl_hit_cnt",  32'(hit_cnt - h0), 32'd1);

        // Asynchronous reset mid-READ while SDA is driven low
        tx_base = tx_req_cnt;
        tx_tbl[0] = 8'h00; tx_tbl[1] = 8'h00;
        i2c_start();
        send_byte(8'h35, ack0);
        wait_q();
        check_val("ar_driving", 32'(bus_if.sda_oen), 32'd0);
        #1 rst = 1'b1;
        #1;
        check_val("ar_sda_oen", 32'(bus_if.sda_oen), 32'd1);
        check_val("ar_state",   32'(dut.state_reg), 32'(ST_IDLE));
        check_val("ar_busy",    32'(bus_if.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_q();
        $display("txn async_reset: mid-read reset, sda_oen=%0b", bus_if.sda_oen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
